// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Owns the fetch PC, drives IM and registers the IF/ID payload.
//             Optional FETCH_SEQ_PERF_EN adds fetch/bubble performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [4:0]  ADEL_CODE  = 5'h4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    input  logic [4:0]  im_exc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic [4:0]  if_exc_code
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_WAIT_EXC = 2'd3
    } state_t;

    state_t      st_q, st_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [4:0]  if_exc_q, if_exc_d;
    logic        w_bubble;

    always_comb begin
        st_d       = st_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        if_exc_d   = if_exc_q;
        w_bubble   = 1'b0;

        if (exc_req) begin
            pc_d     = HANDLER_PC;
            st_d     = ST_FLUSH;
            w_bubble = 1'b1;
        end else if (eret_req) begin
            pc_d     = epc;
            st_d     = ST_FLUSH;
            w_bubble = 1'b1;
        end else if (st_q == ST_WAIT_EXC) begin
            // Parked on a fetch fault until CP0 redirects; stall is irrelevant here.
            w_bubble = 1'b1;
        end else if (stall) begin
            // Freeze PC, state and payload.
        end else if (st_q == ST_BOOT || st_q == ST_FLUSH) begin
            w_bubble = 1'b1;
            st_d     = ST_RUN;
        end else if (im_exc == ADEL_CODE) begin
            if_instr_d = 32'h0;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            if_exc_d   = im_exc;
            st_d       = ST_WAIT_EXC;
        end else begin
            if_instr_d = im_instr;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            if_exc_d   = im_exc;
            pc_d       = br_taken ? br_target : pc_q + 32'd4;
        end

        if (w_bubble) begin
            if_instr_d = 32'h0;
            if_pc_d    = pc_q;
            if_valid_d = 1'b0;
            if_exc_d   = 5'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= ST_BOOT;
            pc_q       <= RESET_PC;
            if_instr_q <= 32'h0;
            if_pc_q    <= 32'h0;
            if_valid_q <= 1'b0;
            if_exc_q   <= 5'h0;
        end else begin
            st_q       <= st_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            if_exc_q   <= if_exc_d;
        end
    end

    assign im_addr     = pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign if_exc_code = if_exc_q;

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;
    logic        w_clean_fetch;

    // A clean fetch is a newly latched valid payload without an exception tag.
    assign w_clean_fetch = !w_bubble && !stall && (st_q == ST_RUN) && (if_exc_d == 5'h0)
                           && !exc_req && !eret_req;

    always_comb begin
        perf_fetch_d  = perf_fetch_q;
        perf_bubble_d = perf_bubble_q;
        if (w_clean_fetch) perf_fetch_d = perf_fetch_q + 32'd1;
        if (w_bubble)      perf_bubble_d = perf_bubble_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q  <= 32'h0;
            perf_bubble_q <= 32'h0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_fetch  = perf_fetch_q;
    assign perf_bubble = perf_bubble_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Scoreboard bench for fetch_sequencer with a behavioural IM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, exc_req, eret_req;
    logic [31:0] br_target, epc, im_addr, im_instr, if_instr, if_pc;
    logic [4:0]  im_exc, if_exc_code;
    logic        if_valid;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_fetch, perf_bubble;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .exc_req     (exc_req),
        .eret_req    (eret_req),
        .epc         (epc),
        .im_addr     (im_addr),
        .im_instr    (im_instr),
        .im_exc      (im_exc),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_valid    (if_valid),
        .if_exc_code (if_exc_code)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_bubble (perf_bubble)
`endif
    );

    // Instruction memory: misaligned or null addresses raise AdEL (code 4).
    function automatic logic [31:0] im_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction
    function automatic logic [4:0] im_code(input logic [31:0] a);
        return (a[1:0] != 2'b00 || a == 32'h0) ? 5'h4 : 5'h0;
    endfunction

    assign im_instr = im_word(im_addr);
    assign im_exc   = im_code(im_addr);

    typedef struct packed {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic [31:0] addr;
    } exp_t;

    typedef struct packed {
        logic        rs, s, b;
        logic [31:0] t;
        logic        e, r;
        logic [31:0] ep;
    } stim_t;

    exp_t sb[$];

    // Reference model state
    logic [31:0] m_pc   = 32'h0;
    logic        m_skip = 1'b1;
    logic        m_wait = 1'b0;
    exp_t        m_out  = '0;

    function automatic stim_t mk(input logic rs, s, b, input logic [31:0] t,
                                 input logic e, r, input logic [31:0] ep);
        stim_t x;
        x.rs = rs; x.s = s; x.b = b; x.t = t; x.e = e; x.r = r; x.ep = ep;
        return x;
    endfunction

    task automatic drive(input stim_t st);
        exp_t        x;
        logic [31:0] mi;
        logic [4:0]  me;
        reset = st.rs; stall = st.s; br_taken = st.b; br_target = st.t;
        exc_req = st.e; eret_req = st.r; epc = st.ep;
        mi = im_word(m_pc);
        me = im_code(m_pc);
        x  = m_out;
        if (st.rs) begin
            x = '0; m_pc = 32'h3000; m_skip = 1'b1; m_wait = 1'b0;
        end else if (st.e || st.r) begin
            x.v = 1'b0; x.instr = '0; x.exc = '0;
            m_pc = st.e ? 32'h4180 : st.ep; m_skip = 1'b1; m_wait = 1'b0;
        end else if (m_wait) begin
            x.v = 1'b0; x.instr = '0; x.exc = '0;
        end else if (st.s) begin
            x = m_out;
        end else if (m_skip) begin
            x.v = 1'b0; x.instr = '0; x.exc = '0; m_skip = 1'b0;
        end else begin
            x.v = 1'b1; x.pc = m_pc; x.exc = me;
            x.instr = (me == 5'h4) ? 32'h0 : mi;
            if (me == 5'h4) m_wait = 1'b1;
            else            m_pc = st.b ? st.t : m_pc + 32'd4;
        end
        x.addr = m_pc;
        m_out  = x;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = sb.pop_front();
            vectors++;
            if ({if_valid, if_instr, if_exc_code, im_addr} !== {e.v, e.instr, e.exc, e.addr}
                || (e.v && if_pc !== e.pc)) begin
                miscompares++;
                $display("FAIL reset[%0d] got v=%b pc=%h ins=%h exc=%h addr=%h want v=%b pc=%h ins=%h exc=%h addr=%h",
                         i, if_valid, if_pc, if_instr, if_exc_code, im_addr, e.v, e.pc, e.instr, e.exc, e.addr);
            end
        end
        vectors++;
        if ({if_valid, if_instr, if_pc, if_exc_code, im_addr} !== {1'b0, 32'h0, 32'h0, 5'h0, 32'h3000}) begin
            miscompares++;
            $display("FAIL reset_state got v=%b ins=%h pc=%h exc=%h addr=%h want 0/0/0/0/3000",
                     if_valid, if_instr, if_pc, if_exc_code, im_addr);
        end
    endtask

    task automatic test_sequential;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0));
            e = sb.pop_front();
            vectors++;
            if ({if_valid, if_instr, if_exc_code, im_addr} !== {e.v, e.instr, e.exc, e.addr}
                || (e.v && if_pc !== e.pc)) begin
                miscompares++;
                $display("FAIL seq[%0d] got v=%b pc=%h ins=%h exc=%h addr=%h want v=%b pc=%h ins=%h exc=%h addr=%h",
                         i, if_valid, if_pc, if_instr, if_exc_code, im_addr, e.v, e.pc, e.instr, e.exc, e.addr);
            end
        end
        vectors++;
        if (if_pc !== 32'h3004 || if_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL seq_pc got pc=%h v=%b want pc=00003004 v=1", if_pc, if_valid);
        end
    endtask

    task automatic test_branch;
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(0, 0, 1, 32'h3100, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h3200, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = sb.pop_front();
            vectors++;
            if ({if_valid, if_instr, if_exc_code, im_addr} !== {e.v, e.instr, e.exc, e.addr}
                || (e.v && if_pc !== e.pc)) begin
                miscompares++;
                $display("FAIL branch[%0d] got v=%b pc=%h ins=%h exc=%h addr=%h want v=%b pc=%h ins=%h exc=%h addr=%h",
                         i, if_valid, if_pc, if_instr, if_exc_code, im_addr, e.v, e.pc, e.instr, e.exc, e.addr);
            end
        end
        vectors++;
        if (if_pc !== 32'h3204) begin
            miscompares++;
            $display("FAIL branch_pc got pc=%h want 00003204", if_pc);
        end
    endtask

    task automatic test_stall;
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h3500, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = sb.pop_front();
            vectors++;
            if ({if_valid, if_instr, if_exc_code, im_addr} !== {e.v, e.instr, e.exc, e.addr}
                || (e.v && if_pc !== e.pc)) begin
                miscompares++;
                $display("FAIL stall[%0d] got v=%b pc=%h ins=%h exc=%h addr=%h want v=%b pc=%h ins=%h exc=%h addr=%h",
                         i, if_valid, if_pc, if_instr, if_exc_code, im_addr, e.v, e.pc, e.instr, e.exc, e.addr);
            end
        end
        vectors++;
        if (if_pc !== 32'h320C || im_addr !== 32'h3210) begin
            miscompares++;
            $display("FAIL stall_resume got pc=%h addr=%h want 0000320c 00003210", if_pc, im_addr);
        end
    endtask

    task automatic test_fetch_error;
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(0, 0, 1, 32'h3002, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h3300, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h3100, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = sb.pop_front();
            vectors++;
            if ({if_valid, if_instr, if_exc_code, im_addr} !== {e.v, e.instr, e.exc, e.addr}
                || (e.v && if_pc !== e.pc)) begin
                miscompares++;
                $display("FAIL fetch_err[%0d] got v=%b pc=%h ins=%h exc=%h addr=%h want v=%b pc=%h ins=%h exc=%h addr=%h",
                         i, if_valid, if_pc, if_instr, if_exc_code, im_addr, e.v, e.pc, e.instr, e.exc, e.addr);
            end
            if (i == 1) begin
                vectors++;
                if ({if_pc, if_exc_code, if_instr, if_valid} !== {32'h3002, 5'h4, 32'h0, 1'b1}) begin
                    miscompares++;
                    $display("FAIL adel_tag got pc=%h exc=%h ins=%h v=%b want 00003002 04 0 1",
                             if_pc, if_exc_code, if_instr, if_valid);
                end
            end
        end
        vectors++;
        if (if_pc !== 32'h4184 || if_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL handler_run got pc=%h v=%b want 00004184 1", if_pc, if_valid);
        end
    endtask

    task automatic test_exc_eret;
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h3040));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h3040));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = sb.pop_front();
            vectors++;
            if ({if_valid, if_instr, if_exc_code, im_addr} !== {e.v, e.instr, e.exc, e.addr}
                || (e.v && if_pc !== e.pc)) begin
                miscompares++;
                $display("FAIL exc_eret[%0d] got v=%b pc=%h ins=%h exc=%h addr=%h want v=%b pc=%h ins=%h exc=%h addr=%h",
                         i, if_valid, if_pc, if_instr, if_exc_code, im_addr, e.v, e.pc, e.instr, e.exc, e.addr);
            end
            if (i == 0) begin
                vectors++;
                if (im_addr !== 32'h4180) begin
                    miscompares++;
                    $display("FAIL exc_wins got addr=%h want 00004180", im_addr);
                end
            end
        end
        vectors++;
        if (if_pc !== 32'h3044) begin
            miscompares++;
            $display("FAIL eret_run got pc=%h want 00003044", if_pc);
        end
    endtask

    task automatic test_wrap;
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = sb.pop_front();
            vectors++;
            if ({if_valid, if_instr, if_exc_code, im_addr} !== {e.v, e.instr, e.exc, e.addr}
                || (e.v && if_pc !== e.pc)) begin
                miscompares++;
                $display("FAIL wrap[%0d] got v=%b pc=%h ins=%h exc=%h addr=%h want v=%b pc=%h ins=%h exc=%h addr=%h",
                         i, if_valid, if_pc, if_instr, if_exc_code, im_addr, e.v, e.pc, e.instr, e.exc, e.addr);
            end
        end
        vectors++;
        if (im_addr !== 32'h0 || if_exc_code !== 5'h4) begin
            miscompares++;
            $display("FAIL wrap_zero got addr=%h exc=%h want 00000000 04", im_addr, if_exc_code);
        end
    endtask

    task automatic test_reset_in_wait;
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(1, 1, 1, 32'h3100, 1, 1, 32'h3040));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            e = sb.pop_front();
            vectors++;
            if ({if_valid, if_instr, if_exc_code, im_addr} !== {e.v, e.instr, e.exc, e.addr}
                || (e.v && if_pc !== e.pc)) begin
                miscompares++;
                $display("FAIL rst_wait[%0d] got v=%b pc=%h ins=%h exc=%h addr=%h want v=%b pc=%h ins=%h exc=%h addr=%h",
                         i, if_valid, if_pc, if_instr, if_exc_code, im_addr, e.v, e.pc, e.instr, e.exc, e.addr);
            end
            if (i == 0) begin
                vectors++;
                if ({if_valid, if_instr, if_pc, if_exc_code, im_addr} !== {1'b0, 32'h0, 32'h0, 5'h0, 32'h3000}) begin
                    miscompares++;
                    $display("FAIL rst_dominates got v=%b ins=%h pc=%h exc=%h addr=%h want 0/0/0/0/3000",
                             if_valid, if_instr, if_pc, if_exc_code, im_addr);
                end
            end
        end
        vectors++;
        if (if_pc !== 32'h3000 || if_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reboot got pc=%h v=%b want 00003000 1", if_pc, if_valid);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        exc_req = 1'b0; eret_req = 1'b0; epc = '0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_fetch_error();
        test_exc_eret();
        test_wrap();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
